// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the execute stage (master) and the
// shared sequential divider controller (slave).
interface div_seq_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_quotient;
  logic [WIDTH-1:0] resp_remainder;

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor, resp_ready,
    input  req_ready, resp_valid, resp_quotient, resp_remainder
  );

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor, resp_ready,
    output req_ready, resp_valid, resp_quotient, resp_remainder
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for a radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu).
// Optional macro DIV_FAST_PATH_EN skips the iteration for trivial quotients.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  div_seq_ctrl_if.slave      bus,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic             accept;
  logic             fast;
  logic             dvd_sign, dsr_sign;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             take;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  // Operand conditioning at accept
  always_comb begin
    dvd_sign = bus.req_signed & bus.req_dividend[WIDTH-1];
    dsr_sign = bus.req_signed & bus.req_divisor[WIDTH-1];
    dvd_mag  = cond_neg(bus.req_dividend, dvd_sign);
    dsr_mag  = cond_neg(bus.req_divisor, dsr_sign);
    accept   = bus.req_valid & bus.req_ready;
`ifdef DIV_FAST_PATH_EN
    fast     = (dsr_mag == '0) || (dvd_mag < dsr_mag);
`else
    fast     = 1'b0;
`endif
  end

  // Trial subtraction; the extra top bit of trial is the borrow
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dsr_q};
    take    = ~trial[WIDTH+1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      res_quo_q    <= '0;
      res_rem_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      res_quo_q    <= res_quo_d;
      res_rem_q    <= res_rem_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dsr_q   <= dsr_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = fast ? FIX : CALC;
        CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    if (resp_valid_q && bus.resp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    if (accept) begin
      q_neg_d = dvd_sign ^ dsr_sign;
      r_neg_d = dvd_sign;
      dsr_d   = dsr_mag;
      cnt_d   = CNT_W'(WIDTH);
      if (fast) begin
        // Zero divisor pre-loads what the full iteration would produce
        quo_d = (dsr_mag == '0) ? '1 : '0;
        rem_d = dvd_mag;
      end else begin
        quo_d = dvd_mag;
        rem_d = '0;
      end
    end else if (state_q == CALC) begin
      rem_d = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], take};
      cnt_d = cnt_q - CNT_W'(1);
    end else if (state_q == FIX && !flush) begin
      res_quo_d = cond_neg(quo_q, q_neg_q);
      res_rem_d = cond_neg(rem_q, r_neg_q);
    end
  end

  always_comb begin
    bus.req_ready      = (state_q == IDLE) && !flush && !reset;
    busy               = (state_q != IDLE);
    resp_valid_d       = !flush && (state_q == DONE) &&
                         !(resp_valid_q && bus.resp_ready);
    bus.resp_valid     = resp_valid_q;
    bus.resp_quotient  = res_quo_q;
    bus.resp_remainder = res_rem_q;
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, signed/unsigned results,
// divide by zero, flush, backpressure and reset behaviour.
module tb_div_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;
  int   checks = 0;
  int   errors = 0;

`ifdef DIV_FAST_PATH_EN
  localparam int FP_LAT = 2;
`else
  localparam int FP_LAT = 34;
`endif

  div_seq_ctrl_if #(.WIDTH(32)) intf ();

  div_seq_ctrl #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (intf),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic sgn, input logic [31:0] dvd, input logic [31:0] dsr);
    intf.req_valid    = 1'b1;
    intf.req_signed   = sgn;
    intf.req_dividend = dvd;
    intf.req_divisor  = dsr;
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] dvd,
                         input logic [31:0] dsr, input int lat, input logic [31:0] eq,
                         input logic [31:0] er, input logic hand);
    int n;
    drive_req(sgn, dvd, dsr);
    #1;
    chk({tag, "_req_ready"}, 32'(intf.req_ready), 32'd1);
    tick();
    intf.req_valid    = 1'b0;
    intf.req_signed   = ~sgn;
    intf.req_dividend = 32'hDEADBEEF;
    intf.req_divisor  = 32'h00000003;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (intf.resp_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_quotient"}, intf.resp_quotient, eq);
    chk({tag, "_remainder"}, intf.resp_remainder, er);
    if (hand) begin
      intf.resp_ready = 1'b1;
      tick();
      intf.resp_ready = 1'b0;
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_valid_after"}, 32'(intf.resp_valid), 32'd0);
    end
  endtask

  initial begin
    logic seen;
    logic [31:0] hold_q, hold_r;
    reset             = 1'b1;
    flush             = 1'b0;
    intf.req_valid    = 1'b0;
    intf.req_signed   = 1'b0;
    intf.req_dividend = '0;
    intf.req_divisor  = '0;
    intf.resp_ready   = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(intf.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(intf.resp_valid), 32'd0);
    chk("rst_quotient", intf.resp_quotient, 32'd0);
    chk("rst_remainder", intf.resp_remainder, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", 32'(intf.req_ready), 32'd1);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b1);
    run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 34, 32'hFFFFFFFD, 32'd1, 1'b1);
    run_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 32'd0, 1'b1);
    run_div("u_big", 1'b0, 32'hFFFFFFFF, 32'h00010000, 34, 32'h0000FFFF, 32'h0000FFFF, 1'b1);
    run_div("u_div0", 1'b0, 32'h00001234, 32'd0, FP_LAT, 32'hFFFFFFFF, 32'h00001234, 1'b1);
    run_div("s_div0", 1'b1, 32'hFFFFFFFB, 32'd0, FP_LAT, 32'h00000001, 32'hFFFFFFFB, 1'b1);
    run_div("u3_10", 1'b0, 32'd3, 32'd10, FP_LAT, 32'd0, 32'd3, 1'b1);

    // Request alongside flush in IDLE must be dropped
    flush = 1'b1;
    drive_req(1'b0, 32'd5, 32'd5);
    #1;
    chk("flush_idle_req_ready", 32'(intf.req_ready), 32'd0);
    tick();
    flush          = 1'b0;
    intf.req_valid = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);

    // Flush mid-CALC
    drive_req(1'b0, 32'd100, 32'd7);
    tick();
    intf.req_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_calc_busy", 32'(busy), 32'd0);
    chk("flush_calc_valid", 32'(intf.resp_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (intf.resp_valid === 1'b1) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_div("u5_5", 1'b0, 32'd5, 32'd5, 34, 32'd1, 32'd0, 1'b1);

    // Backpressure in DONE
    run_div("bp", 1'b0, 32'd1000, 32'd10, 34, 32'd100, 32'd0, 1'b0);
    hold_q = intf.resp_quotient;
    hold_r = intf.resp_remainder;
    repeat (20) begin
      tick();
      chk("bp_valid", 32'(intf.resp_valid), 32'd1);
      chk("bp_quotient", intf.resp_quotient, 32'd100);
      chk("bp_req_ready", 32'(intf.req_ready), 32'd0);
    end
    chk("bp_remainder", intf.resp_remainder, hold_r);
    chk("bp_quotient_hold", intf.resp_quotient, hold_q);
    intf.resp_ready = 1'b1;
    tick();
    intf.resp_ready = 1'b0;
    chk("bp_release_req_ready", 32'(intf.req_ready), 32'd1);
    chk("bp_release_valid", 32'(intf.resp_valid), 32'd0);

    // Flush in DONE keeps the result registers
    run_div("fd", 1'b0, 32'd9, 32'd4, 34, 32'd2, 32'd1, 1'b0);
    flush           = 1'b1;
    intf.resp_ready = 1'b1;
    tick();
    flush           = 1'b0;
    intf.resp_ready = 1'b0;
    chk("fd_valid", 32'(intf.resp_valid), 32'd0);
    chk("fd_busy", 32'(busy), 32'd0);
    chk("fd_quotient_kept", intf.resp_quotient, 32'd2);

    // Reset mid-CALC, with a request presented during reset
    drive_req(1'b0, 32'd100, 32'd7);
    tick();
    intf.req_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    drive_req(1'b0, 32'd5, 32'd5);
    #1;
    chk("rst_mid_req_ready", 32'(intf.req_ready), 32'd0);
    tick();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(intf.resp_valid), 32'd0);
    chk("rst_mid_quotient", intf.resp_quotient, 32'd0);
    chk("rst_mid_remainder", intf.resp_remainder, 32'd0);
    reset          = 1'b0;
    intf.req_valid = 1'b0;
    tick();
    chk("rst_req_dropped", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
